// File: rtl/snn_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : snn_run_controller
// Description : Loads the SNN core configuration from a host byte stream and
//               sequences timesteps (input byte, enable, delay tick, output).
// Revision    : 1.0 - initial release
// ============================================================================
module snn_run_controller #(
    parameter int DCLK_HIGH = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_valid,
    input  logic [7:0]   cfg_data,
    output logic         cfg_ready,
    input  logic         start,
    input  logic [7:0]   num_steps,
    input  logic         in_valid,
    input  logic [7:0]   in_spikes,
    output logic         in_ready,
    output logic         out_valid,
    output logic [7:0]   out_spikes,
    input  logic         out_ready,
    output logic         snn_reset,
    output logic         snn_enable,
    output logic         snn_delay_clk,
    output logic [7:0]   snn_in_spikes,
    output logic [255:0] snn_weights,
    output logic [511:0] snn_delays,
    output logic [4:0]   snn_threshold,
    output logic [2:0]   snn_decay,
    output logic [4:0]   snn_refractory,
    input  logic         snn_data_ready,
    input  logic [7:0]   snn_out_spikes,
    output logic         busy,
    output logic         cfg_loaded,
    output logic         done,
    output logic         err_timeout
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_sync    = 3'd1;
    localparam logic [2:0] c_st_wait_in = 3'd2;
    localparam logic [2:0] c_st_compute = 3'd3;
    localparam logic [2:0] c_st_dtick   = 3'd4;
    localparam logic [2:0] c_st_out     = 3'd5;

    localparam logic [7:0] c_to_last   = 8'(TIMEOUT - 1);
    localparam logic [3:0] c_dclk_last = 4'(DCLK_HIGH - 1);
    localparam logic [6:0] c_last_byte = 7'd97;

    logic [2:0]   r_state;
    logic [2:0]   w_next;
    logic [767:0] r_cfg_vec;
    logic [4:0]   r_threshold;
    logic [2:0]   r_decay;
    logic [4:0]   r_refractory;
    logic         r_cfg_loaded;
    logic [6:0]   r_byte_cnt;
    logic [8:0]   r_steps;
    logic [7:0]   r_cyc_cnt;
    logic [3:0]   r_dclk_cnt;
    logic [7:0]   r_in_spikes;
    logic [7:0]   r_out_spikes;
    logic         r_done;
    logic         r_err_timeout;

    logic         w_cfg_acc;
    logic         w_start_acc;
    logic         w_in_acc;
    logic         w_out_acc;
    logic         w_last_step;
    logic         w_timeout;
    logic [9:0]   w_bit_idx;

    always_comb begin
        w_cfg_acc   = (r_state == c_st_idle) && cfg_valid;
        // A pending config byte takes priority over a run request.
        w_start_acc = (r_state == c_st_idle) && start && r_cfg_loaded && !cfg_valid;
        w_in_acc    = (r_state == c_st_wait_in) && in_valid;
        w_out_acc   = (r_state == c_st_out) && out_ready;
        w_last_step = (r_steps == 9'd1);
        w_timeout   = (r_state == c_st_compute) && !snn_data_ready && (r_cyc_cnt == c_to_last);
        w_bit_idx   = {r_byte_cnt, 3'b000};

        w_next = r_state;
        case (r_state)
            c_st_idle:    if (w_start_acc) w_next = c_st_sync;
            c_st_sync:    w_next = c_st_wait_in;
            c_st_wait_in: if (in_valid) w_next = c_st_compute;
            c_st_compute: begin
                if (snn_data_ready)  w_next = c_st_dtick;
                else if (w_timeout)  w_next = c_st_idle;
            end
            c_st_dtick:   if (r_dclk_cnt == c_dclk_last) w_next = c_st_out;
            c_st_out:     if (out_ready) w_next = w_last_step ? c_st_idle : c_st_wait_in;
            default:      w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_vec     <= '0;
            r_threshold   <= '0;
            r_decay       <= '0;
            r_refractory  <= '0;
            r_cfg_loaded  <= 1'b0;
            r_byte_cnt    <= '0;
            r_steps       <= '0;
            r_cyc_cnt     <= '0;
            r_dclk_cnt    <= '0;
            r_in_spikes   <= '0;
            r_out_spikes  <= '0;
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_done <= w_out_acc && w_last_step;

            if (w_cfg_acc) begin
                if (r_byte_cnt == 7'd0) r_cfg_loaded <= 1'b0;
                if (r_byte_cnt < 7'd96) begin
                    r_cfg_vec[w_bit_idx +: 8] <= cfg_data;
                end else if (r_byte_cnt == 7'd96) begin
                    r_threshold <= cfg_data[4:0];
                    r_decay     <= cfg_data[7:5];
                end else begin
                    r_refractory <= cfg_data[4:0];
                    r_cfg_loaded <= 1'b1;
                end
                r_byte_cnt <= (r_byte_cnt == c_last_byte) ? 7'd0 : r_byte_cnt + 7'd1;
            end

            if (w_start_acc) begin
                r_steps       <= (num_steps == 8'd0) ? 9'd256 : {1'b0, num_steps};
                r_err_timeout <= 1'b0;
            end

            if (w_in_acc) begin
                r_in_spikes <= in_spikes;
                r_cyc_cnt   <= '0;
            end

            if (r_state == c_st_compute) begin
                if (snn_data_ready) begin
                    r_out_spikes <= snn_out_spikes;
                    r_dclk_cnt   <= '0;
                end else begin
                    r_cyc_cnt <= r_cyc_cnt + 8'd1;
                end
            end

            if (w_timeout)                r_err_timeout <= 1'b1;
            if (r_state == c_st_dtick)    r_dclk_cnt    <= r_dclk_cnt + 4'd1;
            if (w_out_acc)                r_steps       <= r_steps - 9'd1;
        end
    end

    assign cfg_ready      = (r_state == c_st_idle) && !reset;
    assign in_ready       = (r_state == c_st_wait_in);
    assign out_valid      = (r_state == c_st_out);
    assign out_spikes     = r_out_spikes;
    assign snn_reset      = reset || (r_state == c_st_sync);
    assign snn_enable     = (r_state == c_st_compute);
    assign snn_delay_clk  = (r_state == c_st_dtick);
    assign snn_in_spikes  = r_in_spikes;
    assign snn_weights    = r_cfg_vec[255:0];
    assign snn_delays     = r_cfg_vec[767:256];
    assign snn_threshold  = r_threshold;
    assign snn_decay      = r_decay;
    assign snn_refractory = r_refractory;
    assign busy           = (r_state != c_st_idle);
    assign cfg_loaded     = r_cfg_loaded;
    assign done           = r_done;
    assign err_timeout    = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_snn_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_snn_run_controller
// Description : Randomized scoreboard bench with a behavioural core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_run_controller;

    localparam int DCLK_HIGH = 2;
    localparam int TIMEOUT   = 255;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_valid, cfg_ready, start, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]   cfg_data, num_steps, in_spikes, out_spikes, snn_in_spikes;
    logic         snn_reset, snn_enable, snn_delay_clk, busy, cfg_loaded, done, err_timeout;
    logic [255:0] snn_weights;
    logic [511:0] snn_delays;
    logic [4:0]   snn_threshold, snn_refractory;
    logic [2:0]   snn_decay;
    logic         snn_data_ready = 1'b0;
    logic [7:0]   snn_out_spikes = 8'h00;

    always #5 clk = ~clk;

    snn_run_controller #(.DCLK_HIGH(DCLK_HIGH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .start(start), .num_steps(num_steps), .in_valid(in_valid), .in_spikes(in_spikes),
        .in_ready(in_ready), .out_valid(out_valid), .out_spikes(out_spikes), .out_ready(out_ready),
        .snn_reset(snn_reset), .snn_enable(snn_enable), .snn_delay_clk(snn_delay_clk),
        .snn_in_spikes(snn_in_spikes), .snn_weights(snn_weights), .snn_delays(snn_delays),
        .snn_threshold(snn_threshold), .snn_decay(snn_decay), .snn_refractory(snn_refractory),
        .snn_data_ready(snn_data_ready), .snn_out_spikes(snn_out_spikes), .busy(busy),
        .cfg_loaded(cfg_loaded), .done(done), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [767:0] act, input logic [767:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Core model: answers core_lat enabled cycles after enable rises, output = ~input.
    int core_lat = 4;
    int en_cnt   = 0;
    always @(posedge clk) begin
        if (snn_enable) begin
            en_cnt <= en_cnt + 1;
            if (core_lat > 0 && en_cnt == core_lat - 1) begin
                snn_data_ready <= 1'b1;
                snn_out_spikes <= ~snn_in_spikes;
            end else begin
                snn_data_ready <= 1'b0;
            end
        end else begin
            en_cnt         <= 0;
            snn_data_ready <= 1'b0;
        end
    end

    // Scoreboard and protocol monitor.
    logic [7:0] exp_q[$];
    int   done_cnt = 0, out_cnt = 0, srst_pulses = 0;
    int   dclk_run = 0, en_run = 0, last_en_run = 0, srst_run = 0;
    bit   ign_dclk = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_spk = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            dclk_run = 0; en_run = 0; srst_run = 0; prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (in_valid && in_ready) exp_q.push_back(~in_spikes);
            if (prev_stall) begin
                check("out_hold_valid", out_valid, 1'b1);
                check("out_hold_data", out_spikes, prev_spk);
            end
            if (out_valid) check("in_ready_during_out", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out_unexpected: got %0h expected none", out_spikes);
                end else begin
                    check("out_spikes", out_spikes, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_spk   = out_spikes;
            if (snn_delay_clk) dclk_run++;
            else if (dclk_run > 0) begin
                if (!ign_dclk) check("dclk_high_len", dclk_run, DCLK_HIGH);
                dclk_run = 0;
            end
            if (snn_enable) en_run++;
            else if (en_run > 0) begin last_en_run = en_run; en_run = 0; end
            if (snn_reset) srst_run++;
            else if (srst_run > 0) begin
                check("snn_reset_len", srst_run, 1);
                srst_pulses++;
                srst_run = 0;
            end
        end
    end

    // Configuration reference: the image as a flat byte map.
    logic [767:0] m_vec;
    logic [4:0]   m_th, m_ref;
    logic [2:0]   m_dec;
    logic         m_loaded;
    int           m_cnt;

    task automatic model_reset();
        m_vec = '0; m_th = '0; m_ref = '0; m_dec = '0; m_loaded = 1'b0; m_cnt = 0;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    task automatic send_cfg(input int n, input bit counting, input bit with_start);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = counting ? k[7:0] : 8'($urandom);
            @(posedge clk); #1;
            cfg_valid = 1'b1; cfg_data = b; start = with_start;
            @(negedge clk);
            check("cfg_ready", cfg_ready, 1'b1);
            if (m_cnt == 0) m_loaded = 1'b0;
            if (m_cnt < 96)       m_vec[m_cnt*8 +: 8] = b;
            else if (m_cnt == 96) begin m_th = b[4:0]; m_dec = b[7:5]; end
            else begin m_ref = b[4:0]; m_loaded = 1'b1; end
            m_cnt = (m_cnt == 97) ? 0 : m_cnt + 1;
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    task automatic check_cfg();
        @(negedge clk);
        check("cfg_weights", snn_weights, m_vec[255:0]);
        check("cfg_delays", snn_delays, m_vec[767:256]);
        check("cfg_thr_dec_ref", {snn_threshold, snn_decay, snn_refractory}, {m_th, m_dec, m_ref});
        check("cfg_loaded", cfg_loaded, m_loaded);
    endtask

    task automatic check_reset_outs(input string nm);
        check(nm, {cfg_ready, in_ready, out_valid, out_spikes, snn_reset, snn_enable, snn_delay_clk,
                   snn_in_spikes, busy, cfg_loaded, done, err_timeout},
              {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        check({nm, "_cfgbus"}, {snn_weights, snn_delays, snn_threshold, snn_decay, snn_refractory}, '0);
    endtask

    task automatic pulse_start(input int steps);
        @(posedge clk); #1;
        num_steps = steps[7:0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; num_steps = 8'($urandom);
    endtask

    // One complete run; values per step are fixed (A5/5A/FF) or random.
    task automatic run(input int steps, input int lat, input bit fixed, input bit stall, input bit bp);
        int n, sent, d0, o0, s0, stall_cnt;
        bit stalled_once, c;
        logic [7:0] fixed_v [3];
        fixed_v = '{8'hA5, 8'h5A, 8'hFF};
        n = (steps == 0) ? 256 : steps;
        sent = 0; d0 = done_cnt; o0 = out_cnt; s0 = srst_pulses;
        stall_cnt = 0; stalled_once = 1'b0;
        core_lat = lat;
        out_ready = !stall;
        pulse_start(steps);
        for (int cyc = 0; cyc < 20000 && done_cnt == d0; cyc++) begin
            @(negedge clk);
            c = in_valid && in_ready;
            if (c) sent++;
            if (stall && !stalled_once && out_valid) begin stall_cnt = 10; stalled_once = 1'b1; end
            @(posedge clk); #1;
            if (c) in_valid = 1'b0;
            if (!in_valid && sent < n && (!bp || $urandom_range(0, 3) != 0)) begin
                in_valid  = 1'b1;
                in_spikes = fixed ? fixed_v[sent % 3] : 8'($urandom);
            end
            if (stall_cnt > 0) begin out_ready = 1'b0; stall_cnt--; end
            else if (stall && !stalled_once) out_ready = 1'b0;
            else out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("run_done_once", done_cnt - d0, 1);
        check("run_out_count", out_cnt - o0, n);
        check("run_queue_empty", exp_q.size(), 0);
        check("run_snn_reset_pulses", srst_pulses - s0, 1);
        check("run_idle_after", busy, 1'b0);
    endtask

    initial begin
        int seen_busy, seen_en, d0;
        reset = 1'b1; cfg_valid = 1'b0; cfg_data = 8'h00; start = 1'b0; num_steps = 8'h00;
        in_valid = 1'b0; in_spikes = 8'h00; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("reset_state");
        #1 reset = 1'b0;

        // Partial image: start must be ignored.
        send_cfg(50, 1'b0, 1'b0);
        pulse_start(3);
        seen_busy = 0; seen_en = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) seen_busy++;
            if (snn_enable) seen_en++;
        end
        check("partial_cfg_loaded", cfg_loaded, 1'b0);
        check("partial_no_busy", seen_busy, 0);
        check("partial_no_enable", seen_en, 0);

        // Counting image k=k.
        do_reset(2);
        send_cfg(98, 1'b1, 1'b0);
        @(negedge clk);
        check("k_weights_lo", snn_weights[7:0], 8'h00);
        check("k_weights_hi", snn_weights[255:248], 8'h1F);
        check("k_delays_lo", snn_delays[7:0], 8'h20);
        check("k_thr_dec_ref", {snn_threshold, snn_decay, snn_refractory}, {5'h00, 3'd3, 5'h01});
        check("k_loaded", cfg_loaded, 1'b1);
        check_cfg();

        run(3, 4, 1'b1, 1'b1, 1'b0);
        check_cfg();

        // Config byte beats a simultaneous start and restarts the image.
        send_cfg(1, 1'b0, 1'b1);
        @(negedge clk);
        check("cfg_beats_start_busy", busy, 1'b0);
        check("new_image_clears_loaded", cfg_loaded, 1'b0);
        send_cfg(97, 1'b0, 1'b0);
        check_cfg();

        for (int r = 0; r < 5; r++) run($urandom_range(1, 7), $urandom_range(1, 6), 1'b0, 1'b0, 1'b1);
        run(0, 1, 1'b0, 1'b0, 1'b1);
        check_cfg();

        // Core never answers.
        core_lat = 0;
        d0 = done_cnt;
        out_ready = 1'b1;
        pulse_start(2);
        @(posedge clk); #1;
        in_valid = 1'b1; in_spikes = 8'($urandom);
        for (int cyc = 0; cyc < 20 && !in_ready; cyc++) @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 600 && busy; cyc++) @(negedge clk);
        @(negedge clk);
        check("to_enable_cycles", last_en_run, TIMEOUT);
        check("to_err", err_timeout, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_no_done", done_cnt - d0, 0);
        exp_q.delete();
        run(1, 4, 1'b0, 1'b0, 1'b0);
        check("to_cleared_by_start", err_timeout, 1'b0);

        // Reset while the delay clock is high.
        core_lat = 2;
        pulse_start(2);
        @(posedge clk); #1;
        in_valid = 1'b1; in_spikes = 8'($urandom);
        for (int cyc = 0; cyc < 50 && !snn_delay_clk; cyc++) begin
            @(negedge clk);
            if (in_ready) begin @(posedge clk); #1 in_valid = 1'b0; end
        end
        check("dtick_reached", snn_delay_clk, 1'b1);
        ign_dclk = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outs("reset_in_dtick");
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_loaded", cfg_loaded, 1'b0);
        check("post_reset_dclk", snn_delay_clk, 1'b0);
        ign_dclk = 1'b0;
        model_reset();
        exp_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
